// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the core's load/store request interface. One request is
//   accepted at a time over a valid/ready handshake. The access completes a
//   fixed LATENCY cycles later, and the result is returned over a second
//   valid/ready handshake. Loads support LB/LH/LW/LBU/LHU and stores support
//   SB/SH/SW, with little-endian byte lanes.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE and out of reset)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32I load/store funct3
//   req_wdata   store data, right-aligned
//   rsp_valid   response present
//   rsp_ready   requester accepts the response
//   rsp_rdata   extended load data (0 for stores and errors)
//   rsp_err     access rejected
//
// Configuration
//   DMEM_ERR_EN  when defined, the following accesses are rejected:
//                misaligned accesses, illegal funct3, and out-of-range word
//                indexes. When undefined, rsp_err is always 0, addresses are
//                aligned down, illegal funct3 acts as LW/SW, and the word
//                index wraps.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        mem_we;
  logic [31:0] rd_word;
  logic        illegal_f3;
  logic        access_err;
  logic [1:0]  size_log2;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rsp_rdata_d;

  // The reset gate keeps req_ready low while reset is held, even though the
  // state register already sits in IDLE.
  assign req_ready = reset && (state_q == S_IDLE);
  assign accept    = (state_q == S_IDLE) && req_valid;
  assign mem_we    = (state_q == S_WAIT) && (cnt_q == 4'd0) && we_q && !access_err;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Memory: one byte-wide array per lane, so byte-enable writes need no
  // read-modify-write. The read is registered on the accepting edge. Any
  // earlier store has already committed by then, so the registered word is
  // current when it is used.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (accept) begin
        rd_q <= lane_mem[req_addr[IDX_W+1:2]];
      end
      if (mem_we && wr_be[gi]) begin
        lane_mem[addr_q[IDX_W+1:2]] <= wr_data[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = rd_q;
  end

  // Access decode from the captured request.
  always_comb begin
    if (we_q) begin
      illegal_f3 = f3_q[2] || (f3_q[1:0] == 2'b11);
    end else begin
      illegal_f3 = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
    end
    // Illegal encodings fall back to a full-word access.
    size_log2 = illegal_f3 ? 2'd2 : f3_q[1:0];
    unique case (size_log2)
      2'd0:    off = addr_q[1:0];
      2'd1:    off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
    shifted = rd_word >> {off, 3'b000};
    unique case (size_log2)
      2'd0: begin
        load_val = f3_q[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        wr_be    = 4'b0001 << off;
        wr_data  = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        load_val = f3_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        wr_be    = 4'b0011 << off;
        wr_data  = {2{wdata_q[15:0]}};
      end
      default: begin
        load_val = shifted;
        wr_be    = 4'b1111;
        wr_data  = wdata_q;
      end
    endcase
    rsp_rdata_d = (we_q || access_err) ? 32'd0 : load_val;
  end

`ifdef DMEM_ERR_EN
  assign access_err = illegal_f3
                   || ((f3_q[1:0] == 2'b01) && addr_q[0])
                   || ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00))
                   || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
`else
  // Without error checking, the index simply wraps.
  logic unused_addr_hi;
  assign access_err     = 1'b0;
  assign unused_addr_hi = ^addr_q[31:IDX_W+2];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      f3_q        <= 3'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= access_err;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int passes = 0;

  // Byte-addressed reference memory.
  logic [7:0] mem_m [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Reference model of a single access, built from the load/store rules.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [2:0] f3, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    bit illegal;
    int size;
    int base;
    logic [31:0] v;
    illegal = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = illegal ? 4 : (1 << f3[1:0]);
    rd = 32'd0;
    err = 1'b0;
`ifdef DMEM_ERR_EN
    if (illegal || (addr % size) != 0 || (addr / 4) >= DEPTH) begin
      err = 1'b1;
      return;
    end
`endif
    base = int'(((addr / 4) % DEPTH) * 4 + ((addr % 4) / size) * size);
    if (we) begin
      for (int i = 0; i < size; i++) mem_m[base + i] = 8'(wd >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
      if (size < 4 && !f3[2] && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rd = v;
    end
  endfunction

  // Drives one transaction. lat = -1 if the handshake never completed.
  task automatic run(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic err, output int lat);
    int n;
    lat = -1;
    rd = 'x;
    err = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    // Request fields change after acceptance. The DUT must ignore them.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_funct3 = 3'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) begin lat = c; break; end
    end
    if (lat < 0) return;
    repeat (hold) begin @(posedge clk); #1; end
    rd = rsp_rdata;
    err = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready got=%b exp=1", req_ready); else passes++;
    $display("reset: released, req_ready=%b", req_ready);
  endtask

  task automatic test_prefill();
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
    for (int w = 0; w < 32; w++) begin
      model_access(1'b1, 32'(w * 4), 3'b010, 32'd0, mrd, merr);
      run(1'b1, 32'(w * 4), 3'b010, 32'd0, 0, rd, err, lat);
      checks++; if (err !== merr || rd !== mrd) $display("FAIL prefill_%0d got rd=%h err=%b exp rd=%h err=%b", w, rd, err, mrd, merr); else passes++;
    end
    $display("prefill: 32 words zeroed");
  endtask

  task automatic test_load_store();
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
    model_access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, mrd, merr);
    run(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd, err, lat);
    $display("SW 0x10: lat=%0d rd=%h err=%b", lat, rd, err);
    checks++; if (lat !== LAT) $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT); else passes++;
    checks++; if (rd !== 32'd0 || err !== 1'b0) $display("FAIL sw_rsp got rd=%h err=%b exp rd=0 err=0", rd, err); else passes++;
    run(1'b0, 32'h10, 3'b010, 32'd0, 0, rd, err, lat);
    $display("LW 0x10: rd=%h", rd);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_10 got=%h exp=deadbeef", rd); else passes++;
    checks++; if (lat !== LAT) $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT); else passes++;
    run(1'b0, 32'h13, 3'b000, 32'd0, 1, rd, err, lat);
    $display("LB 0x13: rd=%h", rd);
    checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_13 got=%h exp=ffffffde", rd); else passes++;
    run(1'b0, 32'h13, 3'b100, 32'd0, 0, rd, err, lat);
    $display("LBU 0x13: rd=%h", rd);
    checks++; if (rd !== 32'h000000DE) $display("FAIL lbu_13 got=%h exp=000000de", rd); else passes++;
    run(1'b0, 32'h10, 3'b001, 32'd0, 0, rd, err, lat);
    $display("LH 0x10: rd=%h", rd);
    checks++; if (rd !== 32'hFFFFBEEF) $display("FAIL lh_10 got=%h exp=ffffbeef", rd); else passes++;
    run(1'b0, 32'h12, 3'b101, 32'd0, 2, rd, err, lat);
    $display("LHU 0x12: rd=%h", rd);
    checks++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_12 got=%h exp=0000dead", rd); else passes++;
    model_access(1'b1, 32'h11, 3'b000, 32'h00000055, mrd, merr);
    run(1'b1, 32'h11, 3'b000, 32'h00000055, 0, rd, err, lat);
    run(1'b0, 32'h10, 3'b010, 32'd0, 0, rd, err, lat);
    $display("SB 0x11 then LW 0x10: rd=%h", rd);
    checks++; if (rd !== 32'hDEAD55EF) $display("FAIL sb_11 got=%h exp=dead55ef", rd); else passes++;
    model_access(1'b1, 32'h12, 3'b001, 32'h00001234, mrd, merr);
    run(1'b1, 32'h12, 3'b001, 32'h00001234, 0, rd, err, lat);
    run(1'b0, 32'h10, 3'b010, 32'd0, 0, rd, err, lat);
    $display("SH 0x12 then LW 0x10: rd=%h", rd);
    checks++; if (rd !== 32'h123455EF) $display("FAIL sh_12 got=%h exp=123455ef", rd); else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
`ifdef DMEM_ERR_EN
    run(1'b0, 32'h12, 3'b010, 32'd0, 0, rd, err, lat);
    $display("LW 0x12 (misaligned): rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'd0) $display("FAIL err_lw_misalign got rd=%h err=%b exp rd=0 err=1", rd, err); else passes++;
    run(1'b0, 32'h11, 3'b101, 32'd0, 0, rd, err, lat);
    $display("LHU 0x11 (misaligned): rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'd0) $display("FAIL err_lh_misalign got rd=%h err=%b exp rd=0 err=1", rd, err); else passes++;
    model_access(1'b1, 32'h400, 3'b010, 32'hCAFEF00D, mrd, merr);
    run(1'b1, 32'h400, 3'b010, 32'hCAFEF00D, 0, rd, err, lat);
    $display("SW 0x400 (out of range): rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'd0) $display("FAIL err_sw_range got rd=%h err=%b exp rd=0 err=1", rd, err); else passes++;
    model_access(1'b0, 32'h0, 3'b010, 32'd0, mrd, merr);
    run(1'b0, 32'h0, 3'b010, 32'd0, 0, rd, err, lat);
    checks++; if (rd !== mrd) $display("FAIL err_no_write got=%h exp=%h", rd, mrd); else passes++;
    run(1'b0, 32'h10, 3'b011, 32'd0, 0, rd, err, lat);
    $display("load funct3=011: rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'd0) $display("FAIL err_f3 got rd=%h err=%b exp rd=0 err=1", rd, err); else passes++;
`else
    run(1'b0, 32'h12, 3'b010, 32'd0, 0, rd, err, lat);
    $display("LW 0x12 (aligned down): rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b0 || rd !== 32'h123455EF) $display("FAIL align_lw got rd=%h err=%b exp rd=123455ef err=0", rd, err); else passes++;
    run(1'b0, 32'h10, 3'b011, 32'd0, 0, rd, err, lat);
    $display("load funct3=011 (as LW): rd=%h err=%b", rd, err);
    checks++; if (err !== 1'b0 || rd !== 32'h123455EF) $display("FAIL f3_as_lw got rd=%h err=%b exp rd=123455ef err=0", rd, err); else passes++;
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
    int n;
    model_access(1'b0, 32'h10, 3'b010, 32'd0, mrd, merr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== LAT) $display("FAIL bp_latency got=%0d exp=%0d", n, LAT); else passes++;
    for (int c = 0; c < 5; c++) begin
      // A competing store is offered while the response is stalled.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== mrd || req_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got valid=%b rd=%h rdy=%b exp valid=1 rd=%h rdy=0", c, rsp_valid, rsp_rdata, req_ready, mrd);
      else passes++;
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    $display("backpressure release: valid=%b rdy=%b rd=%h", rsp_valid, req_ready, rsp_rdata);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0)
      $display("FAIL bp_release got valid=%b rdy=%b rd=%h exp valid=0 rdy=1 rd=0", rsp_valid, req_ready, rsp_rdata);
    else passes++;
    run(1'b0, 32'h10, 3'b010, 32'd0, 0, rd, err, lat);
    checks++; if (rd !== mrd) $display("FAIL bp_ignored_store got=%h exp=%h", rd, mrd); else passes++;
  endtask

  task automatic test_reset_midwait();
    logic [31:0] rd;
    logic err;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL midwait_reset got valid=%b rd=%h err=%b rdy=%b exp 0/0/0/0", rsp_valid, rsp_rdata, rsp_err, req_ready);
    else passes++;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL midwait_no_rsp got=%b exp=0", rsp_valid); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL midwait_release got=%b exp=1", req_ready); else passes++;
    run(1'b0, 32'h20, 3'b010, 32'd0, 0, rd, err, lat);
    $display("LW 0x20 after aborted store: rd=%h", rd);
    checks++; if (rd !== 32'd0) $display("FAIL midwait_discard got=%h exp=00000000", rd); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, addr, wd;
    logic err, merr, we;
    logic [2:0] f3;
    int lat;
    int hold;
    for (int t = 0; t < 60; t++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      addr = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 127))
                                         : 32'($urandom_range(0, 127));
      model_access(we, addr, f3, wd, mrd, merr);
      run(we, addr, f3, wd, hold, rd, err, lat);
      $display("rand %0d: we=%b addr=%h f3=%0d wd=%h -> rd=%h err=%b lat=%0d", t, we, addr, f3, wd, rd, err, lat);
      checks++; if (lat !== LAT) $display("FAIL rand_lat_%0d got=%0d exp=%0d", t, lat, LAT); else passes++;
      checks++; if (rd !== mrd || err !== merr) $display("FAIL rand_rsp_%0d got rd=%h err=%b exp rd=%h err=%b", t, rd, err, mrd, merr); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_load_store();
    test_errors();
    test_backpressure();
    test_reset_midwait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave end) of the core's load/store request interface. It accepts one request at a time over a valid/ready handshake.
- Each access takes a fixed number of wait cycles. The block then returns a response over a second valid/ready handshake.
- Loads return RV32I LB/LH/LW/LBU/LHU data, sign- or zero-extended by funct3. Stores perform SB/SH/SW byte-lane writes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of 2).
- LATENCY, 2, wait cycles from request acceptance to response (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_funct3  input  3  RV32I load/store funct3.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; wait counter = 0.
  - req_ready=0 while reset is asserted, 1 in the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The memory array is not reset.
- FSM IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: capture we/addr/funct3/wdata, load counter = LATENCY-1, go to WAIT.
- FSM WAIT:
  - req_ready=0.
  - If counter != 0, decrement.
  - If counter == 0: perform the access, register rsp_rdata/rsp_err, go to RESP.
  - rsp_valid therefore rises exactly LATENCY cycles after the accepting edge.
- FSM RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On an edge with rsp_ready=1: go to IDLE, clear rsp_valid, rsp_rdata and rsp_err.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Request signals are sampled only on the accepting edge; later changes are ignored.
- Word index = addr[31:2]; byte lane = addr[1:0]; byte ordering is little-endian.
- Loads:
  - 000 LB: sign-extends byte lane.
  - 100 LBU: zero-extends byte lane.
  - 001 LH: sign-extends the halfword at addr[1].
  - 101 LHU: zero-extends the halfword at addr[1].
  - 010 LW: full word.
- Stores:
  - 000 SB: writes wdata[7:0] to the selected lane.
  - 001 SH: writes wdata[15:0] to the selected halfword.
  - 010 SW: writes all 32 bits.
  - Unselected lanes are unchanged.
- Error conditions (with DMEM_ERR_EN):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - funct3 not listed above for the given req_we;
  - addr[31:2] >= DEPTH_WORDS.
- On error: no write occurs, rsp_err=1, rsp_rdata=0. A response is still returned.
- Store response: rsp_rdata=0, rsp_err=0 when legal. The write commits on the WAIT→RESP edge.
- Reset mid-transaction: if reset is asserted before the WAIT→RESP edge, the store is discarded. A pending response is dropped.
- A load from a word written by the immediately preceding store returns the new data.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: error checks as above.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are aligned down (halfword ignores addr[0]; word ignores addr[1:0]).
  - Illegal funct3 is treated as LW or SW.
  - Word index wraps modulo DEPTH_WORDS.

Test Plan:
- LATENCY=2. SW addr 0x10 data 0xDEADBEEF accepted at edge 0 -> rsp_valid high after edge 2, rsp_err=0, rsp_rdata=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB addr 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF. SH addr 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is ignored. Release rsp_ready -> IDLE next cycle, req_ready=1.
- DMEM_ERR_EN defined: LW 0x12 -> rsp_err=1, rsp_rdata=0. SW 0x400 (DEPTH 256) -> rsp_err=1, memory unchanged. funct3=011 load -> rsp_err=1. Undefined: LW 0x12 returns word 0x10, rsp_err=0.
- Assert reset during WAIT of SW 0x20 data 0xA5A5A5A5 (old value 0) -> outputs return to reset values immediately, no response. After release, LW 0x20 -> 0x00000000.
